ysyx_22050243_hazard_scoreboard: RTL
====================================

# ysyx_22050243_hazard_scoreboard

Parametrised register scoreboard for the in-order pipeline. It generalises the single-producer load-use check to any number of outstanding long-latency producers: loads, CSR reads and multi-cycle mul/div. It tracks a pending bit per GPR and an outstanding-op counter, and stalls ID on RAW, WAW or capacity hazards. It sits beside the ID/EX boundary and is updated from ID (issue), EX (kill) and WB (completion).

## Interface
- `GPR_ADDR_WIDTH`, 5, GPR index width; the scoreboard holds `2**GPR_ADDR_WIDTH` entries.
- `MAX_OUTSTANDING`, 4, maximum long-latency ops in flight (1..2**GPR_ADDR_WIDTH-1).
- `WB_BYPASS`, 1, 1: a same-cycle WB completion clears the hazard for ID combinationally (the register file writes through); 0: ID waits one extra cycle.
- `clk` in 1: the only clock; everything updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `id_valid` in 1: ID holds a valid instruction.
- `id_rs1`, `id_rs2` in GPR_ADDR_WIDTH: source indices.
- `id_rs1_used`, `id_rs2_used` in 1: the source is actually read.
- `id_rd` in GPR_ADDR_WIDTH: destination index.
- `id_rd_wen` in 1: the instruction writes `id_rd`.
- `id_long` in 1: the instruction is a long-latency producer (mem read, CSR read, mul/div).
- `id_issue` in 1: the instruction moves ID→EX this cycle. The pipeline guarantees `id_issue` implies `id_valid & ~stall`.
- `ex_kill` in 1: the instruction in EX is flushed.
- `ex_kill_rd` in GPR_ADDR_WIDTH: rd of the killed instruction.
- `ex_kill_long` in 1: the killed instruction had set a scoreboard entry.
- `wb_valid` in 1: WB retires an instruction.
- `wb_rd` in GPR_ADDR_WIDTH: WB destination.
- `wb_long` in 1: the retiring instruction is a long-latency producer.
- `stall` out 1: hold ID and bubble EX.
- `stall_cause` out 3: bits {full, waw, raw}; may be multi-hot.
- `outstanding` out $clog2(MAX_OUTSTANDING+1): current in-flight count.
- `err` out 1: sticky protocol error.

## Operation
- State: `pending[2**GPR_ADDR_WIDTH-1:0]`, the `outstanding` counter, and `err`. `pending[0]` is hard-wired 0.
- Set: on `id_issue & id_long & id_rd_wen & id_rd!=0`, set `pending[id_rd]` and increment `outstanding`.
- Clear (completion): on `wb_valid & wb_long & wb_rd!=0`, clear `pending[wb_rd]` and decrement `outstanding`.
- Clear (kill): on `ex_kill & ex_kill_long & ex_kill_rd!=0`, clear `pending[ex_kill_rd]` and decrement `outstanding`.
- Counter: net change = sets − clears (range −2..+1) applied in one update. Increment and decrement in the same cycle leave the count unchanged.
- Simultaneous set and clear of the same index: set wins. This case arises only when WB_BYPASS=1 and a WB clear coincides with a WAW-free reissue.
- Effective pending for ID: `eff = pending & ~clr_wb` when WB_BYPASS=1, else `eff = pending`. Kill clears never bypass.
- Hazard conditions, all qualified by `id_valid`:
  - raw = `(id_rs1_used & eff[id_rs1]) | (id_rs2_used & eff[id_rs2])`.
  - waw = `id_rd_wen & eff[id_rd]`.
  - full = `id_long & id_rd_wen & (outstanding == MAX_OUTSTANDING)`; not bypassed by a same-cycle completion.
- `stall = raw | waw | full`. Index 0 never causes a hazard.
- `err` is set and held until `rst` on any of:
  - a completion or kill that targets a non-pending register;
  - a decrement at count 0;
  - `id_issue` asserted while `stall` is high.

## Timing
- Reset values: `pending` all 0, `outstanding` 0, `err` 0. `stall` and `stall_cause` are 0 whenever `id_valid` is 0.
- `rst` mid-operation discards all pending state at that edge. Completions arriving afterwards raise `err` only if they are presented after reset deasserts; the bench must quiesce.
- `stall` and `stall_cause` are combinational from inputs and the registered state; there is no added latency.
- A set at edge N is visible to the hazard checks from cycle N+1.
- With WB_BYPASS=1, a dependent in ID issues in the same cycle its producer retires. With WB_BYPASS=0, it issues one cycle later.
- Short-latency producers are not tracked here; the EX/MEM forwarding network covers them.

## Test plan
- Load-use: issue `lw x5` (long), then `add x6,x5,x1` held in ID → `stall`=1 with cause=raw. WB retires x5 at cycle T: with WB_BYPASS=1, `stall`=0 in cycle T; with WB_BYPASS=0, `stall`=0 in T+1.
- Capacity: MAX_OUTSTANDING=4, issue 4 long ops to x1..x4, 5th long op to x7 → `stall`=1 with cause=full and `outstanding`=4. One WB completion → cause=full drops on the next cycle.
- WAW: pending x8, ID `mul x8` → cause=waw. A source-only use of x9 in the same cycle → no stall.
- Kill: issue a long op to x10, then `ex_kill` with `ex_kill_rd`=10 → next cycle `pending[10]`=0, `outstanding` decremented, `err`=0.
- Simultaneous: the same cycle has an issue of a long op to x3 and a WB completion on x4 → `outstanding` unchanged, x3 set, x4 clear. x0 destination or source → never pending, never stalls.
- Protocol/reset: a WB long completion on non-pending x12 → `err`=1 and sticky. Asserting `rst` mid-stream → all state 0, `err`=0 on the next cycle.

Source files
------------

// File: rtl/ysyx_22050243_hazard_scoreboard_if.sv
// Scoreboard bundle: ID issue, EX kill and WB completion inputs, plus the
// stall/status outputs returned to the pipeline.
interface ysyx_22050243_hazard_scoreboard_if #(
  parameter int unsigned GPR_ADDR_WIDTH  = 5,
  parameter int unsigned MAX_OUTSTANDING = 4
);
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

  logic                      id_valid;
  logic [GPR_ADDR_WIDTH-1:0] id_rs1;
  logic [GPR_ADDR_WIDTH-1:0] id_rs2;
  logic                      id_rs1_used;
  logic                      id_rs2_used;
  logic [GPR_ADDR_WIDTH-1:0] id_rd;
  logic                      id_rd_wen;
  logic                      id_long;
  logic                      id_issue;
  logic                      ex_kill;
  logic [GPR_ADDR_WIDTH-1:0] ex_kill_rd;
  logic                      ex_kill_long;
  logic                      wb_valid;
  logic [GPR_ADDR_WIDTH-1:0] wb_rd;
  logic                      wb_long;
  logic                      stall;
  logic [2:0]                stall_cause;
  logic [CW-1:0]             outstanding;
  logic                      err;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
           id_rd_wen, id_long, id_issue, ex_kill, ex_kill_rd, ex_kill_long,
           wb_valid, wb_rd, wb_long,
    input  stall, stall_cause, outstanding, err
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
           id_rd_wen, id_long, id_issue, ex_kill, ex_kill_rd, ex_kill_long,
           wb_valid, wb_rd, wb_long,
    output stall, stall_cause, outstanding, err
  );
endinterface

// File: rtl/ysyx_22050243_hazard_scoreboard.sv
// Register scoreboard: pending bit per GPR plus an in-flight counter for
// long-latency producers; stalls ID on RAW, WAW or capacity hazards.
module ysyx_22050243_hazard_scoreboard #(
  parameter int unsigned GPR_ADDR_WIDTH  = 5,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter bit          WB_BYPASS       = 1'b1
) (
  input  logic                               clk,
  input  logic                               rst,
  ysyx_22050243_hazard_scoreboard_if.slave   sb
);
  localparam int unsigned NREG = 2 ** GPR_ADDR_WIDTH;
  localparam int unsigned CW   = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned EW   = CW + 2;

  logic [NREG-1:0] pending_q, pending_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;

  logic            set_en, clr_wb_en, clr_kill_en;
  logic [NREG-1:0] clr_wb_vec, clr_kill_vec, set_vec, eff;
  logic            raw, waw, full, stall;
  logic [EW-1:0]   inc_sum, dec_sum;
  logic            underflow, bad_target;

  // Decode update strobes and evaluate hazards against the effective pending set.
  always_comb begin
    set_en      = sb.id_issue & sb.id_long & sb.id_rd_wen & (sb.id_rd != '0);
    clr_wb_en   = sb.wb_valid & sb.wb_long & (sb.wb_rd != '0);
    clr_kill_en = sb.ex_kill & sb.ex_kill_long & (sb.ex_kill_rd != '0);

    set_vec      = set_en      ? (NREG'(1) << sb.id_rd)      : '0;
    clr_wb_vec   = clr_wb_en   ? (NREG'(1) << sb.wb_rd)      : '0;
    clr_kill_vec = clr_kill_en ? (NREG'(1) << sb.ex_kill_rd) : '0;

    // Only WB completions may bypass; kills and capacity always see registered state.
    eff = WB_BYPASS ? (pending_q & ~clr_wb_vec) : pending_q;

    raw   = sb.id_valid & ((sb.id_rs1_used & eff[sb.id_rs1]) |
                           (sb.id_rs2_used & eff[sb.id_rs2]));
    waw   = sb.id_valid & sb.id_rd_wen & eff[sb.id_rd];
    full  = sb.id_valid & sb.id_long & sb.id_rd_wen & (cnt_q == CW'(MAX_OUTSTANDING));
    stall = raw | waw | full;

    sb.stall       = stall;
    sb.stall_cause = {full, waw, raw};
    sb.outstanding = cnt_q;
    sb.err         = err_q;
  end

  // Next-state: apply clears then sets (set wins on the same index), net counter change.
  always_comb begin
    pending_d    = (pending_q & ~clr_wb_vec & ~clr_kill_vec) | set_vec;
    pending_d[0] = 1'b0;

    inc_sum   = EW'(cnt_q) + EW'(set_en);
    dec_sum   = EW'(clr_wb_en) + EW'(clr_kill_en);
    underflow = (inc_sum < dec_sum);
    cnt_d     = underflow ? '0 : CW'(inc_sum - dec_sum);

    // Two clears of one index in a cycle: the second one hits a non-pending entry.
    bad_target = (clr_wb_en & ~pending_q[sb.wb_rd]) |
                 (clr_kill_en & ~pending_q[sb.ex_kill_rd]) |
                 (clr_wb_en & clr_kill_en & (sb.wb_rd == sb.ex_kill_rd));

    err_d = err_q | bad_target | underflow | (sb.id_issue & stall);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end
endmodule
